mem_arbiter: RTL

//  Parametrised successor of the single-port I/D memory controller: arbitrates NUM_CH requesters
//  (ch0 = dcache/data, ch1 = icache, higher = DMA/debug) onto one RAM port with busy handshake.

---
 rtl/cpu_types_pkg.sv | 18 +
 rtl/arb_picker.sv | 27 ++
 rtl/mem_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: machine word, memory-arbiter FSM states and access kinds.
// Imported by the memory arbiter and its grant picker.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } mem_arb_state_t;

    typedef enum logic {
        RD = 1'b0,
        WR = 1'b1
    } mem_op_t;

endpackage

// File: rtl/arb_picker.sv
// Combinational grant picker: the first requester found at or after `start`, searching upward
// with wrap-around. A start of 0 gives fixed lowest-index priority.
module arb_picker #(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  start,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  idx,
    output logic              valid
);

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!valid && req[(int'(start) + i) % NUM_CH]) begin
                valid = 1'b1;
                idx   = IDX_W'((int'(start) + i) % NUM_CH);
                grant[(int'(start) + i) % NUM_CH] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// NUM_CH-requester arbiter onto a single RAM port with busy handshake.
// Define MEM_ARB_RR_EN for round-robin grants; otherwise the lowest channel index wins.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [NUM_CH-1:0]        req_ren,
    input  logic [NUM_CH-1:0]        req_wen,
    input  logic [NUM_CH*ADDR_W-1:0] req_addr,
    input  logic [NUM_CH*DATA_W-1:0] req_store,
    output logic [NUM_CH*DATA_W-1:0] req_load,
    output logic [NUM_CH-1:0]        req_ready,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic [DATA_W-1:0]        ram_store,
    output logic                     ram_ren,
    output logic                     ram_wen,
    input  logic [DATA_W-1:0]        ram_load,
    input  logic                     ram_busy,
    output mem_arb_state_t           dbg_state
);

    localparam int IDX_W = $clog2(NUM_CH);

    // Handshake: a requester raises ren/wen (level) with addr/store stable and keeps it up until
    // its req_ready bit pulses for one cycle; it must drop the request in that cycle or it is
    // granted again. On the RAM side an access completes in the first cycle with a strobe high
    // and ram_busy low; ram_load is taken in that same cycle.

    mem_arb_state_t state, state_nxt;

    logic [NUM_CH-1:0] req_any;
    logic [NUM_CH-1:0] pick_grant;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_valid;
    logic [IDX_W-1:0]  start_idx;
    logic              grant_take;
    logic              access_done;

    logic [IDX_W-1:0]  cur_idx;
    logic [NUM_CH-1:0] cur_oh;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_store;
    mem_op_t           cur_op;

    assign req_any     = req_ren | req_wen;
    assign grant_take  = (state == IDLE) && pick_valid;
    assign access_done = (state == ACCESS) && !ram_busy;

`ifdef MEM_ARB_RR_EN
    // rr_ptr holds the index where the next search begins: one past the last winner.
    logic [IDX_W-1:0] rr_ptr;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rr_ptr <= '0;
        end else if (grant_take) begin
            rr_ptr <= (pick_idx == IDX_W'(NUM_CH - 1)) ? '0 : pick_idx + 1'b1;
        end
    end

    assign start_idx = rr_ptr;
`else
    assign start_idx = '0;
`endif

    arb_picker #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_picker (
        .req   (req_any),
        .start (start_idx),
        .grant (pick_grant),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_valid) state_nxt = ACCESS;
            ACCESS:  if (!ram_busy) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The winner's request is frozen at grant; later changes by the requester are ignored.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cur_idx   <= '0;
            cur_oh    <= '0;
            cur_addr  <= '0;
            cur_store <= '0;
            cur_op    <= RD;
        end else if (grant_take) begin
            cur_idx   <= pick_idx;
            cur_oh    <= pick_grant;
            cur_addr  <= req_addr[pick_idx*ADDR_W +: ADDR_W];
            cur_store <= req_store[pick_idx*DATA_W +: DATA_W];
            cur_op    <= req_wen[pick_idx] ? WR : RD;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            req_load <= '0;
        end else if (access_done && (cur_op == RD)) begin
            req_load[cur_idx*DATA_W +: DATA_W] <= ram_load;
        end
    end

    // Strobes and ready decode straight from the state register so reset clears them at once.
    assign ram_addr  = cur_addr;
    assign ram_store = cur_store;
    assign ram_ren   = (state == ACCESS) && (cur_op == RD);
    assign ram_wen   = (state == ACCESS) && (cur_op == WR);
    assign req_ready = (state == RESP) ? cur_oh : '0;
    assign dbg_state = state;

endmodule
